// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, PSR flag indices, branch condition codes,
// per-class flag-update masks and the condition evaluator used by branch logic.
package alu_pkg;

  localparam logic [7:0] OP_ADD    = 8'h00;
  localparam logic [7:0] OP_ADDI   = 8'h08;
  localparam logic [7:0] OP_ADDU   = 8'h10;
  localparam logic [7:0] OP_ADDUI  = 8'h18;
  localparam logic [7:0] OP_ADDC   = 8'h20;
  localparam logic [7:0] OP_ADDCU  = 8'h28;
  localparam logic [7:0] OP_ADDCUI = 8'h30;
  localparam logic [7:0] OP_ADDCI  = 8'h38;
  localparam logic [7:0] OP_SUB    = 8'h40;
  localparam logic [7:0] OP_SUBI   = 8'h48;
  localparam logic [7:0] OP_CMP    = 8'h50;
  localparam logic [7:0] OP_CMPI   = 8'h58;
  localparam logic [7:0] OP_AND    = 8'h60;
  localparam logic [7:0] OP_OR     = 8'h68;
  localparam logic [7:0] OP_XOR    = 8'h70;
  localparam logic [7:0] OP_NOT    = 8'h78;
  localparam logic [7:0] OP_LSH    = 8'h80;
  localparam logic [7:0] OP_LSHI   = 8'h88;
  localparam logic [7:0] OP_RSH    = 8'h90;
  localparam logic [7:0] OP_RSHI   = 8'h98;
  localparam logic [7:0] OP_ALSH   = 8'hA0;
  localparam logic [7:0] OP_ARSH   = 8'hA8;
  localparam logic [7:0] OP_NOP    = 8'hB0;

  localparam int FLAG_Z = 4;
  localparam int FLAG_L = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 0;

  localparam logic [3:0] CC_EQ = 4'b0000;
  localparam logic [3:0] CC_NE = 4'b0001;
  localparam logic [3:0] CC_CS = 4'b0010;
  localparam logic [3:0] CC_CC = 4'b0011;
  localparam logic [3:0] CC_HI = 4'b0100;
  localparam logic [3:0] CC_LS = 4'b0101;
  localparam logic [3:0] CC_GT = 4'b0110;
  localparam logic [3:0] CC_LE = 4'b0111;
  localparam logic [3:0] CC_FS = 4'b1000;
  localparam logic [3:0] CC_FC = 4'b1001;
  localparam logic [3:0] CC_LO = 4'b1010;
  localparam logic [3:0] CC_HS = 4'b1011;
  localparam logic [3:0] CC_LT = 4'b1100;
  localparam logic [3:0] CC_GE = 4'b1101;
  localparam logic [3:0] CC_UC = 4'b1110;
  localparam logic [3:0] CC_NV = 4'b1111;

  localparam logic [4:0] MASK_ARITH    = 5'b10101;
  localparam logic [4:0] MASK_UNSIGNED = 5'b10001;
  localparam logic [4:0] MASK_CMP      = 5'b11010;
  localparam logic [4:0] MASK_LOGIC    = 5'b10000;
  localparam logic [4:0] MASK_NONE     = 5'b00000;

  function automatic logic cond_eval(input logic [3:0] cond, input logic [4:0] flags);
    logic z, l, f, n, c;
    z = flags[FLAG_Z];
    l = flags[FLAG_L];
    f = flags[FLAG_F];
    n = flags[FLAG_N];
    c = flags[FLAG_C];
    case (cond)
      CC_EQ:   cond_eval = z;
      CC_NE:   cond_eval = !z;
      CC_CS:   cond_eval = c;
      CC_CC:   cond_eval = !c;
      CC_HI:   cond_eval = l;
      CC_LS:   cond_eval = !l;
      CC_GT:   cond_eval = n;
      CC_LE:   cond_eval = !n;
      CC_FS:   cond_eval = f;
      CC_FC:   cond_eval = !f;
      CC_LO:   cond_eval = !l && !z;
      CC_HS:   cond_eval = l || z;
      CC_LT:   cond_eval = !n && !z;
      CC_GE:   cond_eval = n || z;
      CC_UC:   cond_eval = 1'b1;
      default: cond_eval = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_writeback_stage_if.sv
// ALU-to-writeback input handshake plus the register-file write port.
// slave = the writeback stage's view, master = the surrounding pipeline's view.
interface alu_writeback_stage_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] alu_c;
  logic [4:0]        alu_flags;
  logic [7:0]        alu_opcode;
  logic [REG_AW-1:0] dest_reg;
  logic              wb_valid;
  logic              wb_ready;
  logic [REG_AW-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;

  modport master (
    output in_valid, alu_c, alu_flags, alu_opcode, dest_reg, wb_ready,
    input  in_ready, wb_valid, wb_addr, wb_data
  );

  modport slave (
    input  in_valid, alu_c, alu_flags, alu_opcode, dest_reg, wb_ready,
    output in_ready, wb_valid, wb_addr, wb_data
  );
endinterface

// File: rtl/alu_flag_mask_decode.sv
// Opcode decode: which PSR flags an instruction defines, and whether it writes a register.
// Latency: combinational. Backpressure: none, pure decode.
module alu_flag_mask_decode
  import alu_pkg::*;
(
  input  logic [7:0] opcode,
  output logic [4:0] mask,
  output logic       writes_reg
);

  always_comb begin
    mask       = MASK_NONE;
    writes_reg = 1'b1;
    case (opcode)
      OP_ADD, OP_ADDI, OP_ADDC, OP_ADDCI, OP_SUB, OP_SUBI: mask = MASK_ARITH;
      OP_ADDU, OP_ADDUI, OP_ADDCU, OP_ADDCUI:              mask = MASK_UNSIGNED;
      OP_AND, OP_OR, OP_XOR, OP_NOT, OP_LSH, OP_LSHI,
      OP_RSH, OP_RSHI, OP_ALSH, OP_ARSH:                   mask = MASK_LOGIC;
      OP_CMP, OP_CMPI: begin
        mask       = MASK_CMP;
        writes_reg = 1'b0;
      end
      // NOP and every undefined encoding: no flags, no write
      default: writes_reg = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_writeback_stage.sv
// ALU writeback: one-entry result register to the regfile, PSR with per-opcode masks, retire count.
// Latency 1 cycle; in_ready = !wb_valid || wb_ready. Optional ALU_COND_EVAL_EN adds cond/cond_true.
module alu_writeback_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  alu_writeback_stage_if.slave bus,
  output logic [4:0]       psr,
  output logic             carry_out,
  output logic [CNT_W-1:0] retired
`ifdef ALU_COND_EVAL_EN
  ,
  input  logic [3:0]       cond,
  output logic             cond_true
`endif
);

  logic [4:0]        mask;
  logic              writes_reg;
  logic              accept;
  logic              xfer;
  logic              wb_valid_q;
  logic [REG_AW-1:0] wb_addr_q;
  logic [DATA_W-1:0] wb_data_q;

  alu_flag_mask_decode u_decode (
    .opcode     (bus.alu_opcode),
    .mask       (mask),
    .writes_reg (writes_reg)
  );

  assign bus.in_ready = !wb_valid_q || bus.wb_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign xfer         = wb_valid_q && bus.wb_ready;

  assign bus.wb_valid = wb_valid_q;
  assign bus.wb_addr  = wb_addr_q;
  assign bus.wb_data  = wb_data_q;
  assign carry_out    = psr[FLAG_C];

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      psr        <= '0;
      retired    <= '0;
    end else begin
      // A new write overwrites the entry that is leaving on this same edge
      if (accept && writes_reg) begin
        wb_valid_q <= 1'b1;
        wb_addr_q  <= bus.dest_reg;
        wb_data_q  <= bus.alu_c;
      end else if (xfer) begin
        wb_valid_q <= 1'b0;
      end
      if (accept) begin
        psr     <= (psr & ~mask) | (bus.alu_flags & mask);
        retired <= retired + CNT_W'(1);
      end
    end
  end

`ifdef ALU_COND_EVAL_EN
  assign cond_true = cond_eval(cond, psr);
`endif

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Bench for alu_writeback_stage: directed vector table, handshake/reset sequences,
// randomized traffic against a queue-based reference model, and counter wrap.
module tb_alu_writeback_stage;

  logic        clk;
  logic        reset;
  logic [4:0]  psr;
  logic        carry_out;
  logic [15:0] retired;
`ifdef ALU_COND_EVAL_EN
  logic [3:0]  cond;
  logic        cond_true;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  alu_writeback_stage_if #(.DATA_W(16), .REG_AW(4)) bus ();

  alu_writeback_stage #(.DATA_W(16), .REG_AW(4), .CNT_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .psr       (psr),
    .carry_out (carry_out),
    .retired   (retired)
`ifdef ALU_COND_EVAL_EN
    ,
    .cond      (cond),
    .cond_true (cond_true)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Flag masks straight from the opcode table
  function automatic logic [4:0] ref_mask(input logic [7:0] op);
    case (op)
      8'h00, 8'h08, 8'h20, 8'h38, 8'h40, 8'h48: return 5'b10101;
      8'h10, 8'h18, 8'h28, 8'h30:               return 5'b10001;
      8'h50, 8'h58:                             return 5'b11010;
      8'h60, 8'h68, 8'h70, 8'h78, 8'h80, 8'h88,
      8'h90, 8'h98, 8'hA0, 8'hA8:               return 5'b10000;
      default:                                  return 5'b00000;
    endcase
  endfunction

  // Everything that defines flags writes a register, except the compares
  function automatic bit ref_writes(input logic [7:0] op);
    return (ref_mask(op) != 5'b0) && (op != 8'h50) && (op != 8'h58);
  endfunction

  function automatic bit ref_cond(input logic [3:0] c, input logic [4:0] p);
    bit z, l, f, n, cy;
    z = p[4]; l = p[3]; f = p[2]; n = p[1]; cy = p[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return l;
      4'd5:  return !l;
      4'd6:  return n;
      4'd7:  return !n;
      4'd8:  return f;
      4'd9:  return !f;
      4'd10: return !(l || z);
      4'd11: return l || z;
      4'd12: return !(n || z);
      4'd13: return n || z;
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  typedef struct {
    logic [7:0]  op;
    logic [15:0] c;
    logic [3:0]  dest;
    logic [4:0]  flags;
    logic        exp_wr;
    logic [4:0]  exp_psr;
  } vec_t;

  typedef struct {
    logic [3:0]  addr;
    logic [15:0] data;
  } wr_t;

  vec_t vecs[11];
  wr_t  wq[$];
  logic [7:0] ops[23];

  task automatic drive(input logic v, input logic [7:0] op, input logic [15:0] c,
                       input logic [3:0] dest, input logic [4:0] flags);
    bus.in_valid   = v;
    bus.alu_opcode = op;
    bus.alu_c      = c;
    bus.dest_reg   = dest;
    bus.alu_flags  = flags;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 8'h00, 16'h0, 4'h0, 5'h0);
    bus.wb_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [4:0]  m_psr;
    logic [15:0] m_ret;
    bit          exp_rdy;
    logic [7:0]  op;
    wr_t         w;

    vecs[0]  = '{8'h00, 16'h0000, 4'd3,  5'b10100, 1'b1, 5'b10100};
    vecs[1]  = '{8'h08, 16'h1111, 4'd4,  5'b00011, 1'b1, 5'b00001};
    vecs[2]  = '{8'h50, 16'hDEAD, 4'd5,  5'b11111, 1'b0, 5'b11011};
    vecs[3]  = '{8'h10, 16'h8001, 4'd6,  5'b00000, 1'b1, 5'b01010};
    vecs[4]  = '{8'h70, 16'h00F0, 4'd7,  5'b11111, 1'b1, 5'b11010};
    vecs[5]  = '{8'hB0, 16'h1234, 4'd8,  5'b11111, 1'b0, 5'b11010};
    vecs[6]  = '{8'hFF, 16'h5555, 4'd9,  5'b00000, 1'b0, 5'b11010};
    vecs[7]  = '{8'h40, 16'hFFFE, 4'd15, 5'b00101, 1'b1, 5'b01111};
    vecs[8]  = '{8'h58, 16'h0001, 4'd0,  5'b00000, 1'b0, 5'b00101};
    vecs[9]  = '{8'h88, 16'h4000, 4'd2,  5'b10000, 1'b1, 5'b10101};
    vecs[10] = '{8'h50, 16'h7777, 4'd1,  5'b00011, 1'b0, 5'b00111};

    ops = '{8'h00, 8'h08, 8'h10, 8'h18, 8'h20, 8'h28, 8'h30, 8'h38, 8'h40, 8'h48,
            8'h50, 8'h58, 8'h60, 8'h68, 8'h70, 8'h78, 8'h80, 8'h88, 8'h90, 8'h98,
            8'hA0, 8'hA8, 8'hB0};

`ifdef ALU_COND_EVAL_EN
    cond = 4'd0;
`endif
    do_reset();

    // Reset state
    check("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    check("rst_wb_addr",  32'(bus.wb_addr),  32'd0);
    check("rst_wb_data",  32'(bus.wb_data),  32'd0);
    check("rst_psr",      32'(psr),          32'd0);
    check("rst_carry",    32'(carry_out),    32'd0);
    check("rst_retired",  32'(retired),      32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

`ifdef ALU_COND_EVAL_EN
    cond = 4'b1010;
    #1 check("cond_lo_clear", 32'(cond_true), 32'd1);
`endif

    // Directed table, one instruction per cycle, regfile always ready
    for (int i = 0; i < 11; i++) begin
      drive(1'b1, vecs[i].op, vecs[i].c, vecs[i].dest, vecs[i].flags);
      @(negedge clk);
      check("tbl_wb_valid", 32'(bus.wb_valid), 32'(vecs[i].exp_wr));
      if (vecs[i].exp_wr) begin
        check("tbl_wb_addr", 32'(bus.wb_addr), 32'(vecs[i].dest));
        check("tbl_wb_data", 32'(bus.wb_data), 32'(vecs[i].c));
      end
      check("tbl_psr",     32'(psr),       32'(vecs[i].exp_psr));
      check("tbl_carry",   32'(carry_out), 32'(vecs[i].exp_psr[0]));
      check("tbl_retired", 32'(retired),   32'(i + 1));
`ifdef ALU_COND_EVAL_EN
      if (i == 0) check("cond_lo_zset", 32'(cond_true), 32'd0);
`endif
    end
    drive(1'b0, 8'h00, 16'h0, 4'h0, 5'h0);

    // Backpressure: second instruction stalls upstream until the regfile takes the first
    do_reset();
    bus.wb_ready = 1'b0;
    drive(1'b1, 8'h10, 16'h1234, 4'd1, 5'b00000);
    @(negedge clk);
    drive(1'b1, 8'h70, 16'h00FF, 4'd2, 5'b10000);
    #1;
    check("bp_in_ready",  32'(bus.in_ready), 32'd0);
    check("bp_wb_valid",  32'(bus.wb_valid), 32'd1);
    check("bp_wb_data",   32'(bus.wb_data),  32'h1234);
    check("bp_wb_addr",   32'(bus.wb_addr),  32'd1);
    @(negedge clk);
    check("bp_hold_data", 32'(bus.wb_data),  32'h1234);
    check("bp_hold_ret",  32'(retired),      32'd1);
    check("bp_hold_psr",  32'(psr),          32'd0);
    bus.wb_ready = 1'b1;
    #1 check("bp_release_rdy", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    drive(1'b0, 8'h00, 16'h0, 4'h0, 5'h0);
    check("bp_next_valid", 32'(bus.wb_valid), 32'd1);
    check("bp_next_data",  32'(bus.wb_data),  32'h00FF);
    check("bp_next_addr",  32'(bus.wb_addr),  32'd2);
    check("bp_next_ret",   32'(retired),      32'd2);
    check("bp_next_psr",   32'(psr),          32'b10000);

    // Reset while a write is stuck behind a stalled regfile
    bus.wb_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("rstmid_wb_valid", 32'(bus.wb_valid), 32'd0);
    check("rstmid_psr",      32'(psr),          32'd0);
    check("rstmid_retired",  32'(retired),      32'd0);
    reset = 1'b0;
    bus.wb_ready = 1'b1;
    @(negedge clk);

    // Random traffic against the reference model
    do_reset();
    m_psr = '0;
    m_ret = '0;
    wq.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      op = ($urandom_range(0, 7) == 0) ? 8'($urandom) : ops[$urandom_range(0, 22)];
      drive(1'($urandom_range(0, 9) < 6), op, 16'($urandom), 4'($urandom), 5'($urandom));
      bus.wb_ready = 1'($urandom_range(0, 9) < 7);
`ifdef ALU_COND_EVAL_EN
      cond = 4'($urandom);
`endif
      #1;
      exp_rdy = (wq.size() == 0) || bus.wb_ready;
      check("rnd_in_ready", 32'(bus.in_ready), 32'(exp_rdy));
      check("rnd_wb_valid", 32'(bus.wb_valid), 32'(wq.size() != 0));
      if (wq.size() != 0) begin
        check("rnd_wb_addr", 32'(bus.wb_addr), 32'(wq[0].addr));
        check("rnd_wb_data", 32'(bus.wb_data), 32'(wq[0].data));
      end
      check("rnd_psr",     32'(psr),       32'(m_psr));
      check("rnd_carry",   32'(carry_out), 32'(m_psr[0]));
      check("rnd_retired", 32'(retired),   32'(m_ret));
`ifdef ALU_COND_EVAL_EN
      check("rnd_cond", 32'(cond_true), 32'(ref_cond(cond, m_psr)));
`endif
      if (wq.size() != 0 && bus.wb_ready) void'(wq.pop_front());
      if (bus.in_valid && exp_rdy) begin
        m_psr = (m_psr & ~ref_mask(op)) | (bus.alu_flags & ref_mask(op));
        m_ret = m_ret + 16'd1;
        if (ref_writes(op)) begin
          w.addr = bus.dest_reg;
          w.data = bus.alu_c;
          wq.push_back(w);
        end
      end
      @(negedge clk);
    end

    // Retired counter wraps after 2^16 accepts
    do_reset();
    drive(1'b1, 8'hB0, 16'h0, 4'h0, 5'b11111);
    repeat (65535) @(negedge clk);
    check("wrap_max",  32'(retired), 32'hFFFF);
    @(negedge clk);
    check("wrap_zero", 32'(retired), 32'd0);
    check("wrap_psr",  32'(psr),     32'd0);
    check("wrap_wbv",  32'(bus.wb_valid), 32'd0);
    drive(1'b0, 8'h00, 16'h0, 4'h0, 5'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
